// File: rtl/onehot_run_checker.sv
// onehot_run_checker: receive-side checker for the walking-one generator.
// Follows one run 0x0001 -> 0x8000 -> 0x0000, checks shift and mask words,
// counts completed runs and protocol errors (both saturating at 255), and
// resynchronises on the next 0x0001 after a failure.
module onehot_run_checker (
    input  logic        CLK,
    input  logic        R,
    input  logic        VALID,
    input  logic [15:0] ONEHOT,
    input  logic [15:0] MASK,
    output logic [3:0]  IDX,
    output logic        LOCK,
    output logic        DONE,
    output logic        ERR,
    output logic [7:0]  RUNS,
    output logic [7:0]  ERRCNT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] prev_q, prev_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  runs_q, runs_d;
    logic [7:0]  errcnt_q, errcnt_d;

    logic [15:0] exp_w;
    logic        mok;
    logic [3:0]  enc;

    assign exp_w = prev_q << 1;
    assign mok   = (MASK == (prev_q - 16'd1));

    // Bit position of ONEHOT; only consumed once the word is known one-hot.
    always_comb begin
        enc = 4'd0;
        for (int i = 0; i < 16; i++)
            if (ONEHOT[i]) enc = 4'(i);
    end

    // Next-state and register updates; VALID=0 leaves everything as is.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        idx_d    = idx_q;
        runs_d   = runs_q;
        errcnt_d = errcnt_q;
        if (VALID) begin
            case (state_q)
                S_IDLE: begin
                    if (ONEHOT == 16'h0001) begin
                        state_d = S_TRACK;
                        idx_d   = 4'd0;
                        prev_d  = 16'h0001;
                    end
                end
                S_TRACK: begin
                    if (ONEHOT == exp_w && mok && exp_w != 16'h0000) begin
                        idx_d  = enc;
                        prev_d = ONEHOT;
                    end else if (ONEHOT == 16'h0000 && exp_w == 16'h0000 && mok) begin
                        // Terminal word; IDX keeps 15 from the last one-hot word.
                        state_d = S_DONE;
                        prev_d  = 16'h0000;
                        if (runs_q != 8'hFF) runs_d = runs_q + 8'd1;
                    end else begin
                        state_d = S_ERROR;
                        if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    if (ONEHOT == 16'h0001) begin
                        state_d = S_TRACK;
                        idx_d   = 4'd0;
                        prev_d  = 16'h0001;
                    end else if (ONEHOT == 16'h0000 && MASK == 16'hFFFF) begin
                        state_d = S_DONE;  // generator idling after a run
                    end else begin
                        state_d = S_ERROR;
                        if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
                    end
                end
                S_ERROR: begin
                    // Sticky; only a fresh 0x0001 restarts tracking.
                    if (ONEHOT == 16'h0001) begin
                        state_d = S_TRACK;
                        idx_d   = 4'd0;
                        prev_d  = 16'h0001;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and counter registers with synchronous reset taking priority.
    always_ff @(posedge CLK) begin
        if (R) begin
            state_q  <= S_IDLE;
            prev_q   <= 16'h0000;
            idx_q    <= 4'd0;
            runs_q   <= 8'd0;
            errcnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            idx_q    <= idx_d;
            runs_q   <= runs_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign IDX    = idx_q;
    assign LOCK   = (state_q == S_TRACK);
    assign DONE   = (state_q == S_DONE);
    assign ERR    = (state_q == S_ERROR);
    assign RUNS   = runs_q;
    assign ERRCNT = errcnt_q;

endmodule
